// File: rtl/multu_hilo_if.sv
// Operation-code, operand and result bundle between the ALU control side and the multiplier.
// master drives code/operands and observes results; slave is the multiplier itself.
interface multu_hilo_if #(
  parameter int WIDTH = 32
);
  logic [5:0]       Signal;
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] dataOut;
  logic             busy;
  logic             done;

  modport master (
    output Signal, dataA, dataB,
    input  hi, lo, dataOut, busy, done
  );

  modport slave (
    input  Signal, dataA, dataB,
    output hi, lo, dataOut, busy, done
  );
endinterface

// File: rtl/multu_hilo.sv
// Sequential unsigned shift-add multiplier with HI/LO commit; 32 steps, commit at E32 (early request) or later from READY.
// No backpressure: the caller holds MULTU/HILO to keep the operation alive, any other code aborts it.
module multu_hilo #(
  parameter int         WIDTH      = 32,
  parameter logic [5:0] MULTU_CODE = 6'b011001,
  parameter logic [5:0] HILO_CODE  = 6'b111111,
  parameter logic [5:0] MFHI_CODE  = 6'b010000,
  parameter logic [5:0] MFLO_CODE  = 6'b010010
) (
  input  logic          clk,
  input  logic          rst_n,
  multu_hilo_if.slave   bus
);

  localparam logic [5:0] LAST_STEP = 6'(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    READY = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic [5:0]         count_q, count_d;
  logic               pending_q, pending_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic [2*WIDTH-1:0] step_prod;
  logic [5:0]         step_cnt;
  logic               is_multu;
  logic               is_hilo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      product_q <= '0;
      count_q   <= '0;
      pending_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      product_q <= product_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    product_d = product_q;
    count_d   = count_q;
    pending_d = pending_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    is_multu  = (bus.Signal == MULTU_CODE);
    is_hilo   = (bus.Signal == HILO_CODE);
    step_prod = product_q + (mplier_q[0] ? mcand_q : '0);
    step_cnt  = count_q + 6'd1;

    unique case (state_q)
      IDLE: begin
        if (is_multu) begin
          mcand_d   = {{WIDTH{1'b0}}, bus.dataA};
          mplier_d  = bus.dataB;
          product_d = '0;
          count_d   = '0;
          pending_d = 1'b0;
          state_d   = RUN;
        end
      end

      RUN: begin
        if (is_multu || is_hilo) begin
          product_d = step_prod;
          mcand_d   = mcand_q << 1;
          mplier_d  = mplier_q >> 1;
          count_d   = step_cnt;
          pending_d = pending_q | is_hilo;
          if (step_cnt == LAST_STEP) begin
            // A commit request seen at any point in the run lands on the final step's edge.
            if (pending_q | is_hilo) begin
              hi_d    = step_prod[2*WIDTH-1:WIDTH];
              lo_d    = step_prod[WIDTH-1:0];
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = READY;
            end
          end
        end else begin
          state_d = IDLE;
        end
      end

      READY: begin
        if (is_hilo) begin
          hi_d    = product_q[2*WIDTH-1:WIDTH];
          lo_d    = product_q[WIDTH-1:0];
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (!is_multu) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.dataOut = '0;
    if (bus.Signal == MFHI_CODE) begin
      bus.dataOut = hi_q;
    end else if (bus.Signal == MFLO_CODE) begin
      bus.dataOut = lo_q;
    end
  end

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;

endmodule
